fd_control: RTL and testbench
=============================

FD_CONTROL -- requirements
Module: fd_control

Interface
REQ-001 Parameter XLEN, default 64, width of OFFSET output.
REQ-002 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 instr  in  32  RV64I instruction word; sampled only on acceptance.
REQ-006 instr_valid  in  1  producer has an instruction on instr.
REQ-007 instr_ready  out  1  block can accept; high only in IDLE.
REQ-008 Ra  out  5  FD register-read address A (ALU A / store data).
REQ-009 Rb  out  5  FD register-read address B (ALU B / memory base).
REQ-010 Rw  out  5  FD register-write address.
REQ-011 WE_reg  out  1  FD register-file write enable.
REQ-012 WE_mem  out  1  FD memory write enable.
REQ-013 OFFSET  out  XLEN  sign-extended immediate to FD address adder.
REQ-014 ADD_SUB  out  1  0 = add, 1 = subtract.
REQ-015 OP_MEM  out  1  1 = memory path (ld/sd), 0 = ALU path.
REQ-016 done  out  1  one-cycle pulse when the instruction completes.
REQ-017 illegal  out  1  qualifies done: instruction not decodable, no write performed.
REQ-018 instr_count  out  CNT_W  count of legal instructions completed.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE, SETUP, WRITE, DONE.
REQ-021 Accept: instr_valid && instr_ready at an edge latches instr and moves IDLE->SETUP.
REQ-022 SETUP: Ra/Rb/Rw/OFFSET/ADD_SUB/OP_MEM driven from the decoded latched word; WE_reg = WE_mem = 0; next WRITE (legal) or DONE (illegal).
REQ-023 WRITE: exactly one enable held high for exactly one cycle; all other control outputs stable from SETUP; next DONE.
REQ-024 DONE: done = 1 for one cycle, enables low, control outputs still stable; next IDLE.
REQ-025 Latency: done SHALL be high in the third cycle after the accept edge (legal); second cycle (illegal).
REQ-026 Decode ld (opcode 0000011, funct3 011): Rb = rs1, Rw = rd, OFFSET = sext(I-imm), OP_MEM = 1, WE_reg in WRITE.
REQ-027 Decode sd (opcode 0100011, funct3 011): Ra = rs2, Rb = rs1, OFFSET = sext(S-imm), OP_MEM = 1, WE_mem in WRITE.
REQ-028 Decode add/sub (opcode 0110011, funct3 000, funct7 0000000/0100000): Ra = rs1, Rb = rs2, Rw = rd, OP_MEM = 0, ADD_SUB = funct7[5], OFFSET = 0, WE_reg in WRITE.
REQ-029 Any other encoding SHALL be illegal: illegal = 1 with done, no enable ever asserted, instr_count unchanged.
REQ-030 rd = x0 on ld/add/sub SHALL be legal but WE_reg SHALL stay 0 in WRITE; instr_count still increments.
REQ-031 Unused address fields SHALL be 0.
REQ-032 instr_count increments by 1 on each legal DONE; wraps 2^CNT_W-1 -> 0.
REQ-033 instr_valid while not IDLE SHALL be ignored; the word is held by the producer until accepted.

Reset
REQ-034 rst SHALL force IDLE and zero every output, including instr_count, on the next edge, from any state.
REQ-035 rst mid-instruction SHALL abandon it: no enable asserted after the reset edge, no done.
REQ-036 rst and instr_valid together SHALL not accept; instr_ready = 1 on the first cycle after reset.

Structure
REQ-037 Shared package fd_pkg SHALL hold opcode/funct3/funct7 constants and the state enumeration.
REQ-038 Combinational decode SHALL be a sub-module fd_decoder (instr -> fields, legal flag); FSM and registers in fd_control.

Verification
REQ-039 ld x1,0(x0) = 0x00003083 -> SETUP Rb=0, Rw=1, OFFSET=0, OP_MEM=1; WE_reg=1 one cycle; done 3 cycles after accept; instr_count=1.
REQ-040 ld x5,-8(x2) = 0xFF813283 -> Rb=2, Rw=5, OFFSET=0xFFFF_FFFF_FFFF_FFF8.
REQ-041 add x3,x2,x1 = 0x001101B3 then sub x4,x3,x1 = 0x40118233 -> Ra=2/3, Rb=1, Rw=3/4, ADD_SUB=0/1, OP_MEM=0, one WE_reg pulse each.
REQ-042 sd x3,16(x0) = 0x00303823 -> Ra=3, Rb=0, OFFSET=16, WE_mem=1 one cycle, WE_reg never 1.
REQ-043 0xFFFFFFFF -> done with illegal=1 in second cycle, no enable, count unchanged; add x0,x1,x2 -> no WE_reg, count increments.
REQ-044 rst asserted in WRITE of a sd -> WE_mem low on next edge, no done, all outputs 0, instr_ready=1 next cycle.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared decode constants, FSM state encoding and decoded-instruction record for the FD controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fd_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_DONE
    } fd_state_t;

    // One decoded instruction; imm is the raw 12-bit immediate, widened by the consumer.
    typedef struct packed {
        logic        legal;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic        add_sub;
        logic        op_mem;
        logic        wr_reg;
        logic        wr_mem;
        logic [11:0] imm;
    } dec_t;

endpackage

// File: rtl/fd_control_if.sv
// Instruction handshake plus the registered FD datapath controls, bundled for one controller.
// Latency: none (wiring only).
// Backpressure: producer holds instr/instr_valid until instr_ready is seen at an edge.
interface fd_control_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [4:0]       Ra;
    logic [4:0]       Rb;
    logic [4:0]       Rw;
    logic             WE_reg;
    logic             WE_mem;
    logic [XLEN-1:0]  OFFSET;
    logic             ADD_SUB;
    logic             OP_MEM;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output instr, instr_valid,
        input  instr_ready, Ra, Rb, Rw, WE_reg, WE_mem, OFFSET,
               ADD_SUB, OP_MEM, done, illegal, instr_count
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, Ra, Rb, Rw, WE_reg, WE_mem, OFFSET,
               ADD_SUB, OP_MEM, done, illegal, instr_count
    );
endinterface

// File: rtl/fd_decoder.sv
// Combinational decode of ld / sd / add / sub into FD register addresses, immediate and enables.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output simply follows instr.
module fd_decoder
    import fd_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Unused address fields stay zero; writes to x0 decode as legal with no register write.
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_LOAD: begin
                if (funct3 == F3_DWORD) begin
                    dec.legal  = 1'b1;
                    dec.rb     = rs1;
                    dec.rw     = rd;
                    dec.imm    = instr[31:20];
                    dec.op_mem = 1'b1;
                    dec.wr_reg = (rd != 5'd0);
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_DWORD) begin
                    dec.legal  = 1'b1;
                    dec.ra     = rs2;
                    dec.rb     = rs1;
                    dec.imm    = {funct7, rd};
                    dec.op_mem = 1'b1;
                    dec.wr_mem = 1'b1;
                end
            end
            OPC_OP: begin
                if ((funct3 == F3_ADDSUB) && ((funct7 == F7_ADD) || (funct7 == F7_SUB))) begin
                    dec.legal   = 1'b1;
                    dec.ra      = rs1;
                    dec.rb      = rs2;
                    dec.rw      = rd;
                    dec.add_sub = funct7[5];
                    dec.wr_reg  = (rd != 5'd0);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/fd_control.sv
// FD controller: accepts one instruction, sequences SETUP -> WRITE -> DONE with registered outputs.
// Latency: done in the 3rd cycle after accept (legal), 2nd cycle (illegal).
// Backpressure: instr_ready high only in IDLE; instr_valid elsewhere is ignored.
module fd_control
    import fd_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    fd_control_if.slave  bus
);
    fd_state_t state;
    dec_t      dec;
    logic      legal_q;
    logic      pend_reg;
    logic      pend_mem;

    fd_decoder u_dec (
        .instr (bus.instr),
        .dec   (dec)
    );

    // Controller FSM; every output is a register written here alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            legal_q         <= 1'b0;
            pend_reg        <= 1'b0;
            pend_mem        <= 1'b0;
            // Ready is the one output that comes out of reset high, so a word can be taken immediately.
            bus.instr_ready <= 1'b1;
            bus.Ra          <= '0;
            bus.Rb          <= '0;
            bus.Rw          <= '0;
            bus.WE_reg      <= 1'b0;
            bus.WE_mem      <= 1'b0;
            bus.OFFSET      <= '0;
            bus.ADD_SUB     <= 1'b0;
            bus.OP_MEM      <= 1'b0;
            bus.done        <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.instr_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        state           <= ST_SETUP;
                        bus.instr_ready <= 1'b0;
                        legal_q         <= dec.legal;
                        pend_reg        <= dec.wr_reg;
                        pend_mem        <= dec.wr_mem;
                        bus.Ra          <= dec.ra;
                        bus.Rb          <= dec.rb;
                        bus.Rw          <= dec.rw;
                        bus.OFFSET      <= {{(XLEN-12){dec.imm[11]}}, dec.imm};
                        bus.ADD_SUB     <= dec.add_sub;
                        bus.OP_MEM      <= dec.op_mem;
                    end
                end
                ST_SETUP: begin
                    if (legal_q) begin
                        state       <= ST_WRITE;
                        bus.WE_reg  <= pend_reg;
                        bus.WE_mem  <= pend_mem;
                    end else begin
                        state       <= ST_DONE;
                        bus.done    <= 1'b1;
                        bus.illegal <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state           <= ST_DONE;
                    bus.WE_reg      <= 1'b0;
                    bus.WE_mem      <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.instr_count <= bus.instr_count + 1'b1;
                end
                ST_DONE: begin
                    state           <= ST_IDLE;
                    bus.done        <= 1'b0;
                    bus.illegal     <= 1'b0;
                    bus.instr_ready <= 1'b1;
                    bus.Ra          <= '0;
                    bus.Rb          <= '0;
                    bus.Rw          <= '0;
                    bus.OFFSET      <= '0;
                    bus.ADD_SUB     <= 1'b0;
                    bus.OP_MEM      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fd_control.sv
// Scoreboard bench for fd_control: directed instruction words with hand-computed expectations.
// Latency: checks done timing relative to the accept edge.
// Backpressure: producer holds each word until instr_ready is seen.
module tb_fd_control;
    localparam int XLEN  = 64;
    localparam int CNT_W = 3;

    typedef struct {
        logic [4:0]       ra, rb, rw;
        logic [63:0]      off;
        logic             as, om, ill;
        int               wer, wem;
        logic [CNT_W-1:0] cnt;
        int               acc, lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [CNT_W-1:0] cnt_model = '0;

    fd_control_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    fd_control #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected record; the count model advances only for legal words.
    function automatic exp_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                                input logic [63:0] off, input logic as, input logic om,
                                input logic ill, input int wer, input int wem);
        exp_t e;
        e.ra = ra; e.rb = rb; e.rw = rw; e.off = off; e.as = as; e.om = om;
        e.ill = ill; e.wer = wer; e.wem = wem;
        if (!ill) cnt_model = cnt_model + 1'b1;
        e.cnt = cnt_model;
        e.lat = ill ? 1 : 2;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: snapshots SETUP fields, counts enable pulses, checks everything when done appears.
    logic [4:0]  s_ra, s_rb, s_rw;
    logic [63:0] s_off;
    logic        s_as, s_om;
    int          wr_cnt = 0, wm_cnt = 0;
    logic        prev_rdy = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wr_cnt = 0;
            wm_cnt = 0;
        end else begin
            if (bus.WE_reg) wr_cnt++;
            if (bus.WE_mem) wm_cnt++;
            if (prev_rdy && !bus.instr_ready) begin
                s_ra = bus.Ra; s_rb = bus.Rb; s_rw = bus.Rw;
                s_off = bus.OFFSET; s_as = bus.ADD_SUB; s_om = bus.OP_MEM;
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("setup_Ra", s_ra, e.ra);
                    chk("setup_Rb", s_rb, e.rb);
                    chk("setup_Rw", s_rw, e.rw);
                    chk("setup_OFFSET", s_off, e.off);
                    chk("setup_ADD_SUB", s_as, e.as);
                    chk("setup_OP_MEM", s_om, e.om);
                    chk("done_Ra", bus.Ra, e.ra);
                    chk("done_Rb", bus.Rb, e.rb);
                    chk("done_Rw", bus.Rw, e.rw);
                    chk("done_OFFSET", bus.OFFSET, e.off);
                    chk("done_ADD_SUB", bus.ADD_SUB, e.as);
                    chk("done_OP_MEM", bus.OP_MEM, e.om);
                    chk("illegal", bus.illegal, e.ill);
                    chk("instr_count", bus.instr_count, e.cnt);
                    chk("we_reg_pulses", wr_cnt, e.wer);
                    chk("we_mem_pulses", wm_cnt, e.wem);
                    chk("latency", cyc - e.acc, e.lat);
                end
                wr_cnt = 0;
                wm_cnt = 0;
            end
        end
        prev_rdy = bus.instr_ready;
    end

    // Presents a word at a negedge and holds it until the DUT is ready at the following edge.
    task automatic send(input logic [31:0] w, input exp_t e, input bit push);
        int n = 0;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got instr_ready=0 expected 1 within 20 cycles");
            bus.instr_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        bus.instr_valid = 1'b0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ready"}, bus.instr_ready, 1'b1);
        chk({nm, "_addr"}, {bus.Ra, bus.Rb, bus.Rw}, 15'd0);
        chk({nm, "_we"}, {bus.WE_reg, bus.WE_mem}, 2'b00);
        chk({nm, "_OFFSET"}, bus.OFFSET, 64'd0);
        chk({nm, "_flags"}, {bus.ADD_SUB, bus.OP_MEM, bus.done, bus.illegal}, 4'b0000);
        chk({nm, "_count"}, bus.instr_count, 0);
    endtask

    initial begin
        int n;
        exp_t dummy;
        // Reset with a valid word present: nothing may be accepted.
        bus.instr       = 32'h00003083;
        bus.instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        send(32'h00003083, mk(5'd0, 5'd0, 5'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1, 0), 1'b1);
        send(32'hFF813283, mk(5'd0, 5'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 1'b0, 1, 0), 1'b1);
        send(32'h001101B3, mk(5'd2, 5'd1, 5'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1, 0), 1'b1);
        send(32'h40118233, mk(5'd3, 5'd1, 5'd4, 64'd0, 1'b1, 1'b0, 1'b0, 1, 0), 1'b1);
        send(32'h00303823, mk(5'd3, 5'd0, 5'd0, 64'd16, 1'b0, 1'b1, 1'b0, 0, 1), 1'b1);
        send(32'hFFFFFFFF, mk(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 0, 0), 1'b1);
        send(32'h021101B3, mk(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 0, 0), 1'b1);
        send(32'h00002083, mk(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 0, 0), 1'b1);
        send(32'h00208033, mk(5'd1, 5'd2, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b1);
        send(32'h001101B3, mk(5'd2, 5'd1, 5'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1, 0), 1'b1);
        // Eighth legal completion wraps the 3-bit counter to zero.
        send(32'h40118233, mk(5'd3, 5'd1, 5'd4, 64'd0, 1'b1, 1'b0, 1'b0, 1, 0), 1'b1);
        wait_drain("drain_main");

        // Abort a store in its WRITE cycle.
        dummy = '{ra: 5'd3, rb: 5'd0, rw: 5'd0, off: 64'd16, as: 1'b0, om: 1'b1, ill: 1'b0,
                   wer: 0, wem: 1, cnt: '0, acc: 0, lat: 2};
        send(32'h00303823, dummy, 1'b0);
        bus.instr_valid = 1'b0;
        n = 0;
        while (!bus.WE_mem && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_write", bus.WE_mem, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", bus.done, 1'b0);
        chk("abort_count_zero", bus.instr_count, 0);

        // Recovery after the abort counts from zero again.
        cnt_model = '0;
        send(32'h00003083, mk(5'd0, 5'd0, 5'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1, 0), 1'b1);
        wait_drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
